// File: rtl/complex_mult_scheduler_pkg.sv
// Shared configuration defaults and width helpers for the complex multiplier scheduler.
package complex_mult_scheduler_pkg;

    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefNumReq      = 4;
    localparam int unsigned DefMultLatency = 7;
    localparam int unsigned DefFifoDepth   = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/complex_mult_scheduler_if.sv
// Requester and response handshake bundle between the matrix-engine lanes and the scheduler.
interface complex_mult_scheduler_if
    import complex_mult_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = DefNumReq
);
    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [IdW-1:0]                     rsp_id;
    logic [2*DATA_WIDTH-1:0]            rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/complex_mult_scheduler_rsp_fifo.sv
// Synchronous first-word-fall-through response FIFO with same-cycle push/pop and occupancy count.
module complex_mult_scheduler_rsp_fifo
    import complex_mult_scheduler_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          push_i,
    input  logic [Width-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic                          valid_o,
    output logic [Width-1:0]              data_o,
    output logic [cnt_width(Depth)-1:0]   count_o
);
    localparam int unsigned CntW = cnt_width(Depth);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, wr_en, rd_en;

    always_comb begin
        empty = (count_q == '0);
        // A word pushed into an empty FIFO and popped in the same cycle never lands in storage.
        wr_en = push_i & ~(empty & pop_i);
        rd_en = pop_i & ~empty;

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(wr_en) - CntW'(rd_en);

        valid_o = ~empty | push_i;
        data_o  = ~empty ? mem_q[rd_ptr_q] : (push_i ? push_data_i : '0);
        count_o = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/complex_multiplier.sv
// Non-stallable pipelined complex multiplier: {re,im} halves in, {re,im} full-width product out.
module complex_multiplier #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 7
) (
    input  logic                    clk_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [2*DATA_WIDTH-1:0] p_o
);
    localparam int unsigned HW = DATA_WIDTH / 2;

    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [DATA_WIDTH-1:0] prod_re, prod_im;
    logic [2*DATA_WIDTH-1:0]      pipe_q [LATENCY];

    always_comb begin
        a_re    = {{HW{a_i[DATA_WIDTH-1]}}, a_i[DATA_WIDTH-1:HW]};
        a_im    = {{HW{a_i[HW-1]}}, a_i[HW-1:0]};
        b_re    = {{HW{b_i[DATA_WIDTH-1]}}, b_i[DATA_WIDTH-1:HW]};
        b_im    = {{HW{b_i[HW-1]}}, b_i[HW-1:0]};
        prod_re = a_re * b_re - a_im * b_im;
        prod_im = a_re * b_im + a_im * b_re;
    end

    // Datapath only: validity is tracked by the scheduler's tag pipe, so no reset here.
    always_ff @(posedge clk_i) begin
        pipe_q[0] <= {prod_re, prod_im};
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/complex_mult_scheduler.sv
// Round-robin sharing of one pipelined complex multiplier between NUM_REQ requesters,
// with an ID tag pipe and a credit-guarded response FIFO for result-side backpressure.
module complex_mult_scheduler
    import complex_mult_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned NUM_REQ      = DefNumReq,
    parameter int unsigned MULT_LATENCY = DefMultLatency,
    parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
    input  logic                      clk,
    input  logic                      reset,
    complex_mult_scheduler_if.slave   bus
);
    localparam int unsigned IdW  = id_width(NUM_REQ);
    localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
    localparam int unsigned PW   = 2 * DATA_WIDTH;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [PW-1:0]  p;
    } rsp_t;

    logic [IdW-1:0]                    last_grant_q, last_grant_d;
    logic [CntW-1:0]                   outstanding_q, outstanding_d;
    logic [MULT_LATENCY-1:0]           tag_valid_q, tag_valid_d;
    logic [MULT_LATENCY-1:0][IdW-1:0]  tag_id_q, tag_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grant_id, idx;
    logic               found;
    logic               issue_allowed, issue, push, rsp_valid, rsp_pop;
    logic [DATA_WIDTH-1:0] mul_a, mul_b;
    logic [PW-1:0]      mul_p;
    rsp_t               push_rsp, head_rsp;
    logic               fifo_valid;
    logic [CntW-1:0]    fifo_count;

    // Search starts one past the last winner, so the most recent winner has lowest priority.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IdW'((32'(last_grant_q) + off) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign issue_allowed = (outstanding_q < CntW'(FIFO_DEPTH));
    assign issue         = found & issue_allowed & ~reset;
    assign bus.req_ready = grant & {NUM_REQ{issue_allowed & ~reset}};

    assign mul_a = issue ? bus.req_a[grant_id] : '0;
    assign mul_b = issue ? bus.req_b[grant_id] : '0;

    complex_multiplier #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (MULT_LATENCY)
    ) u_mult (
        .clk_i (clk),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    always_comb begin
        tag_valid_d    = '0;
        tag_id_d       = '0;
        tag_valid_d[0] = issue;
        tag_id_d[0]    = grant_id;
        for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    always_comb begin
        last_grant_d  = issue ? grant_id : last_grant_q;
        outstanding_d = outstanding_q + CntW'(issue) - CntW'(rsp_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= IdW'(NUM_REQ - 1);
            outstanding_q <= '0;
            tag_valid_q   <= '0;
            tag_id_q      <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            tag_valid_q   <= tag_valid_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign push        = tag_valid_q[MULT_LATENCY-1] & ~reset;
    assign push_rsp.id = tag_id_q[MULT_LATENCY-1];
    assign push_rsp.p  = mul_p;

    complex_mult_scheduler_rsp_fifo #(
        .Width ($bits(rsp_t)),
        .Depth (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .push_data_i (push_rsp),
        .pop_i       (rsp_pop),
        .valid_o     (fifo_valid),
        .data_o      (head_rsp),
        .count_o     (fifo_count)
    );

    assign rsp_valid     = fifo_valid & ~reset;
    assign rsp_pop       = rsp_valid & bus.rsp_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_valid ? head_rsp.id : '0;
    assign bus.rsp_p     = rsp_valid ? head_rsp.p : '0;

    // Every FIFO entry holds a credit, so a tag exit can never find the FIFO full.
    assert property (@(posedge clk) disable iff (reset) fifo_count <= outstanding_q);

endmodule

// File: tb/tb_complex_mult_scheduler.sv
// Directed bench for complex_mult_scheduler: latency, round-robin order, credit limit,
// fairness, mid-flight reset and in-order product scoreboard.
module tb_complex_mult_scheduler;

    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 4;
    localparam int unsigned LAT   = 7;
    localparam int unsigned DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    complex_mult_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    complex_mult_scheduler #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .MULT_LATENCY (LAT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [63:0] p;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grants[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          n_hs  = 0;
    int          n_rsp = 0;
    bit          chk_lat = 1'b0;
    bit          hold_v  = 1'b0;
    logic [1:0]  hold_id;
    logic [63:0] hold_p;
    logic [3:0]  last_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] cmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] ar, ai, br, bi, re, im;
        ar = {{16{a[31]}}, a[31:16]};
        ai = {{16{a[15]}}, a[15:0]};
        br = {{16{b[31]}}, b[31:16]};
        bi = {{16{b[15]}}, b[15:0]};
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: sample at edge+2, score handshakes and responses, advance, refresh operands.
    task automatic step();
        exp_t       e;
        logic [3:0] hs;
        #1;
        hs         = bus.req_valid & bus.req_ready;
        last_ready = bus.req_ready;
        check_eq("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
        if (hold_v) begin
            check_eq("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("hold_id", 64'(bus.rsp_id), 64'(hold_id));
            check_eq("hold_p", bus.rsp_p, hold_p);
        end
        hold_v  = bus.rsp_valid & ~bus.rsp_ready;
        hold_id = bus.rsp_id;
        hold_p  = bus.rsp_p;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                e.id  = 2'(i);
                e.p   = cmul(bus.req_a[i], bus.req_b[i]);
                e.cyc = cyc;
                exp_q.push_back(e);
                grants.push_back(i);
                n_hs++;
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                check_eq("rsp_p", bus.rsp_p, e.p);
                if (chk_lat) check_eq("rsp_latency", 64'(cyc - e.cyc), 64'd7);
            end
        end
        tick();
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                bus.req_a[i] = $urandom;
                bus.req_b[i] = $urandom;
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step();
            k++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hs0;
        int rsp0;
        bit seen;

        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset: valid requests are ignored while reset is held
        tick();
        tick();
        #1;
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        reset         = 1'b0;
        bus.req_valid = 4'h0;
        #1;
        check_eq("post_rst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("post_rst_id", 64'(bus.rsp_id), 64'd0);
        check_eq("post_rst_p", bus.rsp_p, 64'd0);
        tick();

        // Single op from requester 2: (3+4i)*(1+2i) = -5+10i
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 32'h0003_0004;
        bus.req_b[2]  = 32'h0001_0002;
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("t1_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = 4'h0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            #1;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                lat  = k;
                check_eq("t1_id", 64'(bus.rsp_id), 64'd2);
                check_eq("t1_p", bus.rsp_p, 64'hFFFF_FFFB_0000_000A);
            end
            tick();
        end
        check_eq("t1_latency", 64'(lat), 64'd7);
        #1;
        check_eq("t1_empty_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("t1_empty_p", bus.rsp_p, 64'd0);
        tick();

        // Full-rate round robin from reset: grants 0,1,2,3,... responses 7 cycles later
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i] = 32'h0001_0001 * (i + 1);
            bus.req_b[i] = 32'h0002_FFFF + 32'(i);
        end
        grants.delete();
        chk_lat       = 1'b1;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 24; k++) step();
        bus.req_valid = 4'h0;
        drain(20);
        chk_lat = 1'b0;
        check_eq("t2_count", 64'(grants.size()), 64'd24);
        for (int k = 0; k < grants.size(); k++) begin
            check_eq("t2_rr_order", 64'(grants[k]), 64'(k % 4));
        end

        // Consumer stalled: exactly FIFO_DEPTH handshakes, then resumption after drain
        hs0           = n_hs;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 20; k++) step();
        check_eq("t3_credit_hs", 64'(n_hs - hs0), 64'd8);
        check_eq("t3_ready_low", 64'(last_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check_eq("t3_resumed", 64'((n_hs - hs0) > 16), 64'd1);
        bus.req_valid = 4'h0;
        drain(40);

        // Fairness between requesters 1 and 3 with a full FIFO and bursty consumer
        grants.delete();
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 45; k++) begin
            bus.rsp_ready = (k >= 15) && (k % 3 != 0);
            step();
        end
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b1;
        drain(40);
        check_eq("t4_enough", 64'(grants.size() >= 10), 64'd1);
        for (int k = 0; k < grants.size(); k++) begin
            check_eq("t4_fair_id", 64'(grants[k] == 1 || grants[k] == 3), 64'd1);
            if (k > 0) check_eq("t4_fair_alt", 64'(grants[k] != grants[k-1]), 64'd1);
        end

        // Reset with three products in flight: they must never surface
        bus.req_valid = 4'hF;
        for (int k = 0; k < 3; k++) step();
        reset = 1'b1;
        step();
        check_eq("t5_rst_ready", 64'(last_ready), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        grants.delete();
        hold_v = 1'b0;
        rsp0   = n_rsp;
        step();
        check_eq("t5_first_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
        bus.req_valid = 4'h0;
        for (int k = 0; k < 15; k++) step();
        check_eq("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        check_eq("t5_rsp_count", 64'(n_rsp - rsp0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
